// File: rtl/snax_tcdm_bank_rr_arbiter.sv
// Round-robin arbiter sharing one TCDM bank between NumInp requesters.
// Read responses follow the winner through a fixed-latency index pipe.
module snax_tcdm_bank_rr_arbiter #(
  parameter int unsigned NumInp     = 4,
  parameter int unsigned AddrWidth  = 10,
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned MemLatency = 1,
  parameter int unsigned StrbWidth  = DataWidth / 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumInp-1:0]             in_q_valid_i,
  output logic [NumInp-1:0]             in_q_ready_o,
  input  logic [NumInp*AddrWidth-1:0]   in_q_addr_i,
  input  logic [NumInp-1:0]             in_q_write_i,
  input  logic [NumInp*DataWidth-1:0]   in_q_data_i,
  input  logic [NumInp*StrbWidth-1:0]   in_q_strb_i,
  output logic [NumInp-1:0]             in_p_valid_o,
  output logic [DataWidth-1:0]          in_p_data_o,
  output logic                          mem_req_o,
  input  logic                          mem_gnt_i,
  output logic [AddrWidth-1:0]          mem_addr_o,
  output logic                          mem_we_o,
  output logic [DataWidth-1:0]          mem_wdata_o,
  output logic [StrbWidth-1:0]          mem_be_o,
  input  logic [DataWidth-1:0]          mem_rdata_i
);

  localparam int unsigned IdxW =
    (NumInp > 1) ? $clog2(NumInp) : 1;

  logic [IdxW-1:0]       rr_q, rr_d;
  logic [IdxW-1:0]       win;
  logic                  hs;
  logic [MemLatency-1:0] pv_q, pv_d;
  logic [IdxW-1:0]       pi_q [MemLatency];
  logic [IdxW-1:0]       pi_d [MemLatency];

  // Scan backwards so the closest valid slot after rr_q wins.
  always_comb begin
    win = rr_q;
    for (int k = NumInp - 1; k >= 0; k--) begin
      int unsigned j;
      j = (int'(rr_q) + k) % NumInp;
      if (in_q_valid_i[j]) win = IdxW'(j);
    end
  end

  assign mem_req_o   = rst_ni & (|in_q_valid_i);
  assign hs          = mem_req_o & mem_gnt_i;
  assign mem_addr_o  = in_q_addr_i[AddrWidth*win +: AddrWidth];
  assign mem_we_o    = in_q_write_i[win];
  assign mem_wdata_o = in_q_data_i[DataWidth*win +: DataWidth];
  assign mem_be_o    = in_q_strb_i[StrbWidth*win +: StrbWidth];

  always_comb begin
    in_q_ready_o      = '0;
    in_q_ready_o[win] = hs;
  end

  always_comb begin
    rr_d = rr_q;
    if (hs) begin
      rr_d = (win == IdxW'(NumInp - 1)) ? '0 : win + 1'b1;
    end
  end

  always_comb begin
    pv_d    = '0;
    pv_d[0] = hs & ~mem_we_o;
    pi_d[0] = win;
    for (int i = 1; i < MemLatency; i++) begin
      pv_d[i] = pv_q[i-1];
      pi_d[i] = pi_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
      pv_q <= '0;
      for (int i = 0; i < MemLatency; i++) pi_q[i] <= '0;
    end else begin
      rr_q <= rr_d;
      pv_q <= pv_d;
      for (int i = 0; i < MemLatency; i++) pi_q[i] <= pi_d[i];
    end
  end

  always_comb begin
    in_p_valid_o = '0;
    in_p_valid_o[pi_q[MemLatency-1]] = pv_q[MemLatency-1];
  end

  assign in_p_data_o = mem_rdata_i;

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert ($onehot0(in_q_ready_o));
      assert ($onehot0(in_p_valid_o));
      assert ((in_q_ready_o & ~in_q_valid_i) == '0);
    end
  end
`endif

endmodule

// File: tb/tb_snax_tcdm_bank_rr_arbiter.sv
// Bench for snax_tcdm_bank_rr_arbiter: directed scenarios plus
// randomized traffic checked against a behavioural model.
module tb_snax_tcdm_bank_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 64;
  localparam int SW = DW / 8;
  localparam int ML = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [N-1:0]  q_valid;
  logic [N-1:0]  q_ready;
  logic [N*AW-1:0] q_addr;
  logic [N-1:0]  q_write;
  logic [N*DW-1:0] q_data;
  logic [N*SW-1:0] q_strb;
  logic [N-1:0]  p_valid;
  logic [DW-1:0] p_data;
  logic          mem_req;
  logic          mem_gnt;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_be;
  logic [DW-1:0] mem_rdata;

  snax_tcdm_bank_rr_arbiter #(
    .NumInp(N), .AddrWidth(AW), .DataWidth(DW), .MemLatency(ML)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_q_valid_i(q_valid), .in_q_ready_o(q_ready),
    .in_q_addr_i(q_addr), .in_q_write_i(q_write),
    .in_q_data_i(q_data), .in_q_strb_i(q_strb),
    .in_p_valid_o(p_valid), .in_p_data_o(p_data),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt),
    .mem_addr_o(mem_addr), .mem_we_o(mem_we),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
    .mem_rdata_i(mem_rdata)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: priority pointer, pending responses by cycle.
  int           m_rr = 0;
  int           cyc = 0;
  int           exp_idx [int];
  int           grant_log [$];
  logic [N-1:0] hs_mask = '0;

  function automatic int m_winner(input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction

  always @(negedge clk_i) begin
    int w;
    logic [N-1:0] er, epv;
    if (!rst_ni) begin
      chk("rst_req", 64'(mem_req), 64'd0);
      chk("rst_ready", 64'(q_ready), 64'd0);
      chk("rst_pvalid", 64'(p_valid), 64'd0);
      m_rr = 0;
      exp_idx.delete();
      hs_mask = '0;
    end else begin
      w  = m_winner(q_valid);
      er = '0;
      if (w >= 0 && mem_gnt) er[w] = 1'b1;
      chk("req", 64'(mem_req), 64'(w >= 0));
      chk("ready", 64'(q_ready), 64'(er));
      if (w >= 0) begin
        chk("addr", 64'(mem_addr), 64'(q_addr[w*AW +: AW]));
        chk("we", 64'(mem_we), 64'(q_write[w]));
        chk("wdata", mem_wdata, q_data[w*DW +: DW]);
        chk("be", 64'(mem_be), 64'(q_strb[w*SW +: SW]));
      end
      epv = '0;
      if (exp_idx.exists(cyc)) epv[exp_idx[cyc]] = 1'b1;
      chk("pvalid", 64'(p_valid), 64'(epv));
      if (epv != '0) chk("pdata", p_data, mem_rdata);
      if (er != '0) begin
        grant_log.push_back(w);
        m_rr = (w + 1) % N;
        if (!q_write[w]) exp_idx[cyc + ML] = w;
      end
      hs_mask = er;
    end
    if (exp_idx.exists(cyc)) exp_idx.delete(cyc);
    cyc++;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    q_valid = '0;
    mem_gnt = 1'b1;
    repeat (ML + 2) tick();
  endtask

  initial begin
    rst_ni    = 1'b0;
    q_valid   = '1;
    q_write   = '0;
    q_strb    = '1;
    mem_gnt   = 1'b1;
    mem_rdata = 64'h0123_4567_89AB_CDEF;
    for (int i = 0; i < N; i++) begin
      q_addr[i*AW +: AW] = AW'(10'h100 + i);
      q_data[i*DW +: DW] = {32'hA5A5_0000 + i, 32'h5A5A_0000 + i};
    end

    // T1: reset holds everything quiet despite requests.
    repeat (3) tick();
    chk("t1_req", 64'(mem_req), 64'd0);
    chk("t1_ready", 64'(q_ready), 64'd0);
    rst_ni  = 1'b1;
    q_valid = '0;
    tick();

    // T2: all requesting, rotation 0,1,2,3,0,1,2,3.
    grant_log.delete();
    q_valid = '1;
    repeat (8) tick();
    q_valid = '0;
    chk("t2_count", 64'(grant_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      chk("t2_order", 64'(grant_log[i]), 64'(i % 4));
    drain();

    // T3: stall then grants to req0 and req2; pointer ends at 3.
    grant_log.delete();
    q_valid = 4'b0101;
    mem_gnt = 1'b0;
    repeat (3) begin
      #1;
      chk("t3_stall_ready", 64'(q_ready), 64'd0);
      tick();
    end
    mem_gnt = 1'b1;
    repeat (2) tick();
    chk("t3_count", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() == 2) begin
      chk("t3_first", 64'(grant_log[0]), 64'd0);
      chk("t3_second", 64'(grant_log[1]), 64'd2);
    end
    q_valid = '1;
    mem_gnt = 1'b0;
    #1;
    chk("t3_ptr_addr", 64'(mem_addr), 64'h103);
    chk("t3_ptr_ready", 64'(q_ready), 64'd0);
    tick();
    drain();

    // T4: read by req1 returns after exactly ML cycles.
    q_addr[1*AW +: AW] = 10'h02A;
    mem_rdata = 64'hDEAD_BEEF_0000_0001;
    q_valid = 4'b0010;
    #1;
    chk("t4_addr", 64'(mem_addr), 64'h02A);
    tick();
    q_valid = '0;
    for (int k = 1; k < ML; k++) begin
      #1;
      chk("t4_early", 64'(p_valid), 64'd0);
      tick();
    end
    #1;
    chk("t4_pvalid", 64'(p_valid), 64'b0010);
    chk("t4_pdata", p_data, 64'hDEAD_BEEF_0000_0001);
    drain();

    // T5: write by req3 produces no response.
    q_addr[3*AW +: AW] = 10'h3FF;
    q_write[3] = 1'b1;
    q_strb[3*SW +: SW] = 8'hF0;
    q_data[3*DW +: DW] = 64'h1122_3344_5566_7788;
    q_valid = 4'b1000;
    #1;
    chk("t5_we", 64'(mem_we), 64'd1);
    chk("t5_be", 64'(mem_be), 64'hF0);
    chk("t5_addr", 64'(mem_addr), 64'h3FF);
    chk("t5_wdata", mem_wdata, 64'h1122_3344_5566_7788);
    tick();
    q_valid = '0;
    q_write[3] = 1'b0;
    repeat (ML + 1) begin
      #1;
      chk("t5_silent", 64'(p_valid), 64'd0);
      tick();
    end

    // T6: reset while a read is in flight drops it.
    q_valid = 4'b0100;
    tick();
    q_valid = '0;
    rst_ni  = 1'b0;
    #1;
    chk("t6_drop", 64'(p_valid), 64'd0);
    tick();
    rst_ni = 1'b1;
    repeat (ML + 1) begin
      #1;
      chk("t6_quiet", 64'(p_valid), 64'd0);
      tick();
    end
    q_valid = '1;
    #1;
    chk("t6_restart", 64'(q_ready), 64'b0001);
    tick();
    drain();

    // Randomized traffic with hold-until-ready requesters.
    q_valid = '0;
    repeat (600) begin
      for (int i = 0; i < N; i++) begin
        if (q_valid[i] && hs_mask[i]) q_valid[i] = 1'b0;
        if (!q_valid[i] && $urandom_range(0, 99) < 50) begin
          q_valid[i] = 1'b1;
          q_addr[i*AW +: AW] = AW'($urandom);
          q_write[i] = 1'($urandom_range(0, 1));
          q_data[i*DW +: DW] = {$urandom, $urandom};
          q_strb[i*SW +: SW] = SW'($urandom);
        end
      end
      mem_gnt   = ($urandom_range(0, 99) < 70);
      mem_rdata = {$urandom, $urandom};
      tick();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
